// File: rtl/lcd_text_framer_if.sv
// Byte-stream input handshake and published-frame outputs of the LCD text framer.
// The master side is the byte source (UART/SPI receiver) and the LCD driver that
// samples the frame; the slave side is the framer itself.
interface lcd_text_framer_if;
  logic [7:0]   rx_data;
  logic         rx_valid;
  logic         rx_ready;
  logic [255:0] chars;
  logic         frame_valid;
  logic [4:0]   cursor;
  logic         busy;

  modport master (
    output rx_data, rx_valid,
    input  rx_ready, chars, frame_valid, cursor, busy
  );

  modport slave (
    input  rx_data, rx_valid,
    output rx_ready, chars, frame_valid, cursor, busy
  );
endinterface

// File: rtl/lcd_text_framer.sv
// lcd_text_framer: composes a byte stream into a 32-character working buffer and
// publishes whole frames on a 256-bit bus (char 0 in the MSBs) for a 16x2 LCD driver.
// Control codes: CR publishes, LF jumps line, BS erases back, FF clears (32 cycles).
// Optional feature macro: LCD_TEXT_FRAMER_AUTO_PUBLISH_EN -- when defined, a character
// written at cursor 31 also publishes the frame in the same edge.
module lcd_text_framer #(
  parameter logic [7:0] FILL_CHAR = 8'h20,
  parameter logic [7:0] SUB_CHAR  = 8'h3F,
  parameter bit         SUB_EN    = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  lcd_text_framer_if.slave   bus
);

  localparam logic [7:0] CODE_BS = 8'h08;
  localparam logic [7:0] CODE_LF = 8'h0A;
  localparam logic [7:0] CODE_FF = 8'h0C;
  localparam logic [7:0] CODE_CR = 8'h0D;

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t       state_q, state_d;
  logic [7:0]   buf_q [32];
  logic [7:0]   buf_d [32];
  logic [255:0] chars_q, chars_d;
  logic [4:0]   cursor_q, cursor_d;
  logic [4:0]   clr_cnt_q, clr_cnt_d;
  logic         rdy_en_q;
  logic         fv_q, fv_d;
  logic         rx_ready_w;
  logic         accept;
  logic         wr_en;
  logic [7:0]   wr_byte;

  // Flatten the working buffer into the published bus layout, char 0 at the top.
  function automatic logic [255:0] pack_frame(input logic [7:0] b [32]);
    logic [255:0] f;
    f = '0;
    for (int i = 0; i < 32; i++) begin
      f[255 - 8*i -: 8] = b[i];
    end
    return f;
  endfunction

  function automatic logic is_printable(input logic [7:0] b);
    return (b >= 8'h20) && (b <= 8'h7E);
  endfunction

  // rdy_en_q holds ready low for the cycle following a reset edge.
  assign rx_ready_w      = rdy_en_q && (state_q == IDLE);
  assign accept          = bus.rx_valid && rx_ready_w;
  assign bus.rx_ready    = rx_ready_w;
  assign bus.chars       = chars_q;
  assign bus.frame_valid = fv_q;
  assign bus.cursor      = cursor_q;
  assign bus.busy        = (state_q == CLEAR);

  // Next-state decode: byte interpretation in IDLE, sequential fill in CLEAR.
  always_comb begin
    state_d   = state_q;
    cursor_d  = cursor_q;
    clr_cnt_d = clr_cnt_q;
    buf_d     = buf_q;
    chars_d   = chars_q;
    fv_d      = 1'b0;
    wr_en     = 1'b0;
    wr_byte   = FILL_CHAR;

    case (state_q)
      IDLE: begin
        if (accept) begin
          if (is_printable(bus.rx_data)) begin
            wr_en   = 1'b1;
            wr_byte = bus.rx_data;
          end else begin
            case (bus.rx_data)
              CODE_CR: begin
                chars_d  = pack_frame(buf_q);
                cursor_d = 5'd0;
                fv_d     = 1'b1;
              end
              CODE_LF: begin
                cursor_d = cursor_q[4] ? 5'd0 : 5'd16;
              end
              CODE_BS: begin
                // Backspace stops at column 0 of line 1; it never wraps.
                if (cursor_q != 5'd0) begin
                  cursor_d                  = cursor_q - 5'd1;
                  buf_d[cursor_q - 5'd1]    = FILL_CHAR;
                end
              end
              CODE_FF: begin
                cursor_d  = 5'd0;
                clr_cnt_d = 5'd0;
                state_d   = CLEAR;
              end
              default: begin
                if (SUB_EN) begin
                  wr_en   = 1'b1;
                  wr_byte = SUB_CHAR;
                end
              end
            endcase
          end

          if (wr_en) begin
            buf_d[cursor_q] = wr_byte;
            cursor_d        = cursor_q + 5'd1;
`ifdef LCD_TEXT_FRAMER_AUTO_PUBLISH_EN
            // Publish includes the byte just written at the last position.
            if (cursor_q == 5'd31) begin
              chars_d = pack_frame(buf_d);
              fv_d    = 1'b1;
            end
`endif
          end
        end
      end

      CLEAR: begin
        buf_d[clr_cnt_q] = FILL_CHAR;
        clr_cnt_d        = clr_cnt_q + 5'd1;
        if (clr_cnt_q == 5'd31) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, buffer and published frame registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cursor_q  <= 5'd0;
      clr_cnt_q <= 5'd0;
      rdy_en_q  <= 1'b0;
      fv_q      <= 1'b0;
      chars_q   <= {32{FILL_CHAR}};
      for (int i = 0; i < 32; i++) begin
        buf_q[i] <= FILL_CHAR;
      end
    end else begin
      state_q   <= state_d;
      cursor_q  <= cursor_d;
      clr_cnt_q <= clr_cnt_d;
      rdy_en_q  <= 1'b1;
      fv_q      <= fv_d;
      chars_q   <= chars_d;
      buf_q     <= buf_d;
    end
  end

endmodule

// File: doc/lcd_text_framer.md
Name: lcd_text_framer

Overview:
- Upstream feeder for the 16x2 character LCD driver.
- Consumes a byte stream (UART/SPI receive side of the slave board) through a valid/ready handshake and composes text into a 32-character working buffer, honouring a small set of control codes.
- Publishes complete frames as the 256-bit `chars` bus the LCD driver samples.
- Frame layout on `chars`: char 0 = top-left = bits [255:248], char 15 = bits [135:128], char 16 = line-2 start = bits [127:120], char 31 = bits [7:0].

Parameters:
- FILL_CHAR, 8'h20, byte written by clear/backspace and at reset.
- SUB_CHAR, 8'h3F, byte written in place of non-printable, non-control input.
- SUB_EN, 1, 1 = non-printables written as SUB_CHAR and advance the cursor; 0 = silently dropped.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- rx_data  in  8  input byte
- rx_valid  in  1  rx_data valid
- rx_ready  out  1  block can accept a byte this cycle
- chars  out  256  published frame, 32 ASCII bytes, char 0 in MSBs
- frame_valid  out  1  one-cycle pulse, cycle after `chars` updates
- cursor  out  5  working-buffer write position, 0..31
- busy  out  1  high while a clear is in progress

Behaviour:
- Reset: one clock and reset only. While rst is high at a clock edge:
  - working buffer and `chars` all FILL_CHAR; cursor = 0; state = IDLE.
  - rx_ready = 0, frame_valid = 0, busy = 0.
  - rx_ready rises in the first cycle after rst deasserts.
- Accept: a byte is accepted on an edge where rx_valid && rx_ready. In IDLE, rx_ready = 1 combinationally from state. The source holds rx_data while rx_ready = 0.
- States: IDLE, CLEAR.
- IDLE, per accepted byte (effects visible the next cycle):
  - 0x20..0x7E: buf[cursor] <= byte; cursor <= cursor+1, wrapping 31->0.
  - 0x0D (CR): chars <= working buffer (includes all bytes accepted earlier); cursor <= 0; frame_valid = 1 on the following cycle only. Buffer is not cleared.
  - 0x0A (LF): cursor <= 16 if cursor < 16, else 0.
  - 0x08 (BS): if cursor > 0, cursor <= cursor-1 and buf[cursor-1] <= FILL_CHAR; at 0, no-op (no wrap).
  - 0x0C (FF): cursor <= 0; go to CLEAR.
  - Any other byte: SUB_EN = 1 → handled as printable SUB_CHAR; SUB_EN = 0 → consumed, no effect.
- CLEAR:
  - rx_ready = 0, busy = 1.
  - Internal 5-bit counter writes FILL_CHAR to buf[0..31], one entry per cycle: exactly 32 cycles.
  - Returns to IDLE after the write to index 31; rx_ready = 1 on the next cycle.
  - `chars` is untouched.
- Latency:
  - byte accepted → buffer/cursor updated: 1 edge.
  - CR accepted → `chars` updated at the same edge; frame_valid high during the next cycle.
  - FF accepted → ready again 33 cycles after acceptance.
- Boundaries:
  - Printable at cursor 31: writes index 31, cursor wraps to 0, overwrites line 1 on the next byte.
  - Back-to-back CRs: each republishes and pulses frame_valid, giving consecutive pulses.
  - rst during CLEAR: clear aborted; full reset values apply.
  - rx_valid high during CLEAR: ignored and not lost, since the source holds it.
- Stability: `chars` changes only on a CR publish or reset, so the LCD driver's once-per-refresh sampling never sees a half-built frame.

Optional Feature:
- Macro: LCD_TEXT_FRAMER_AUTO_PUBLISH_EN.
- Defined: a printable/SUB write at cursor 31 also publishes. `chars` receives the buffer including that byte, in the same edge; frame_valid pulses the next cycle; cursor wraps to 0.
- Undefined: only CR publishes; the wrap just wraps.

Test Plan:
- Reset, then send "HELLO", CR → chars[255:216] = "HELLO", chars[215:0] all 8'h20, one frame_valid pulse, cursor = 0.
- Send "AB", LF, "CD", CR → chars[255:240] = "AB", chars[127:112] = "CD", everything else 8'h20.
- Send "XYZ", BS, BS, CR → chars[255:248] = "X", chars[247:232] = 8'h20, cursor 1 before the CR; then BS ×3 at cursor 0 → cursor stays 0.
- Fill buffer, send FF with rx_valid held high continuously → rx_ready low for 32 cycles, busy high; next byte accepted 33 cycles after FF; after CR, all 32 bytes = 8'h20. Assert rst at CLEAR cycle 10 → reset values next cycle.
- SUB_EN = 1: send 8'h01, CR → chars[255:248] = 8'h3F. SUB_EN = 0: same stimulus → char 0 = 8'h20, cursor 0.
- Macro defined: send 32 × "A" with no CR → frame_valid pulses once, all bytes 8'h41, cursor 0. Macro undefined: no pulse, `chars` unchanged.
